// File: rtl/adder_response_checker.sv
// ---------------------------------------------------------------------------
// adder_response_checker
// Self-checking monitor for a WIDTH-bit full adder. Each accepted vector
// (A, B, Cin plus the adder's Sum/Cout) passes through a fixed 2-stage pipe.
// Stage 2 compares {Cout,Sum} against a golden A+B+Cin. The block counts
// vectors and mismatches, keeps the first failing vector, and reports
// Pass/Done once NumVec vectors have been checked.
//
// Ports
//   Clk, Rst_n        clock / async active-low reset
//   Start, NumVec     arm a run (IDLE or DONE only); NumVec sampled on Start
//   Valid, A, B, Cin  applied vector, qualified by Valid (RUN only)
//   Sum, Cout         adder response for the same vector
//   Busy, Done, Pass  run status (Pass meaningful while Done)
//   VecCount, ErrCount  accepted / mismatching vectors this run (saturating)
//   FailValid, Fail*  sticky capture of the first mismatching vector
// ---------------------------------------------------------------------------
module adder_response_checker #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [CNT_W-1:0] NumVec,
  input  logic             Valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [WIDTH-1:0] Sum,
  input  logic             Cout,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [CNT_W-1:0] VecCount,
  output logic [CNT_W-1:0] ErrCount,
  output logic             FailValid,
  output logic [WIDTH-1:0] FailA,
  output logic [WIDTH-1:0] FailB,
  output logic             FailCin,
  output logic [WIDTH-1:0] FailSum,
  output logic             FailCout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
  } vec_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             s1_valid_q, s1_valid_d;
  vec_t             s1_q, s1_d;
  logic             s2_valid_q, s2_valid_d;
  vec_t             s2_q, s2_d;
  logic             fail_valid_q, fail_valid_d;
  vec_t             fail_q, fail_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             accept;
  logic [WIDTH:0]   exp_full;
  logic             mismatch;

  // State, pipeline and result registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      num_vec_q    <= '0;
      vec_count_q  <= '0;
      err_count_q  <= '0;
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      s2_valid_q   <= 1'b0;
      s2_q         <= '0;
      fail_valid_q <= 1'b0;
      fail_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_vec_q    <= num_vec_d;
      vec_count_q  <= vec_count_d;
      err_count_q  <= err_count_d;
      s1_valid_q   <= s1_valid_d;
      s1_q         <= s1_d;
      s2_valid_q   <= s2_valid_d;
      s2_q         <= s2_d;
      fail_valid_q <= fail_valid_d;
      fail_q       <= fail_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  // Next-state, pipeline advance, compare and status decode
  always_comb begin
    state_d      = state_q;
    num_vec_d    = num_vec_q;
    vec_count_d  = vec_count_q;
    err_count_d  = err_count_q;
    s1_valid_d   = 1'b0;
    s1_d         = s1_q;
    s2_valid_d   = s1_valid_q;
    s2_d         = s1_q;
    fail_valid_d = fail_valid_q;
    fail_d       = fail_q;

    accept   = (state_q == RUN) && Valid;
    exp_full = (WIDTH+1)'(s2_q.a) + (WIDTH+1)'(s2_q.b) + (WIDTH+1)'(s2_q.cin);
    mismatch = s2_valid_q && ({s2_q.cout, s2_q.sum} != exp_full);

    // Stage-2 commit: count the error and keep only the first failing vector
    if (mismatch) begin
      if (err_count_q != CNT_MAX) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
      if (!fail_valid_q) begin
        fail_valid_d = 1'b1;
        fail_d       = s2_q;
      end
    end

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_d       = '{a: A, b: B, cin: Cin, sum: Sum, cout: Cout};
      if (vec_count_q != CNT_MAX) begin
        vec_count_d = vec_count_q + CNT_W'(1);
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          num_vec_d    = NumVec;
          vec_count_d  = '0;
          err_count_d  = '0;
          fail_valid_d = 1'b0;
          fail_d       = '0;
          state_d      = (NumVec == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept && (vec_count_d == num_vec_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Stage 1 empty means stage 2 commits on this edge: the run is complete
        if (!s1_valid_q) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (err_count_d == '0);
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Pass      = pass_q;
  assign VecCount  = vec_count_q;
  assign ErrCount  = err_count_q;
  assign FailValid = fail_valid_q;
  assign FailA     = fail_q.a;
  assign FailB     = fail_q.b;
  assign FailCin   = fail_q.cin;
  assign FailSum   = fail_q.sum;
  assign FailCout  = fail_q.cout;

endmodule

// File: tb/tb_adder_response_checker.sv
// ---------------------------------------------------------------------------
// tb_adder_response_checker
// Table-driven bench for adder_response_checker. Vectors carry the response
// presented to the checker plus the hand-computed golden sum/carry. Each
// accepted vector pushes its expected mismatch onto a scoreboard queue that
// is drained two cycles later, when ErrCount is due to reflect it.
// ---------------------------------------------------------------------------
module tb_adder_response_checker;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 16;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;      // response presented as the adder output
    logic             cout;
    logic [WIDTH-1:0] gold_sum; // hand-computed A+B+Cin
    logic             gold_cout;
  } vec_rec_t;

  typedef struct {
    int   due;
    logic mis;
  } sb_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             valid;
  logic [WIDTH-1:0] a, b, sum;
  logic             cin, cout;
  logic             busy, done, pass;
  logic [CNT_W-1:0] vec_count, err_count;
  logic             fail_valid;
  logic [WIDTH-1:0] fail_a, fail_b, fail_sum;
  logic             fail_cin, fail_cout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_err = 0;
  int exp_vec = 0;
  sb_t sb_q[$];
  vec_rec_t tbl[12];

  adder_response_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk(clk), .Rst_n(rst_n), .Start(start), .NumVec(num_vec), .Valid(valid),
    .A(a), .B(b), .Cin(cin), .Sum(sum), .Cout(cout),
    .Busy(busy), .Done(done), .Pass(pass), .VecCount(vec_count), .ErrCount(err_count),
    .FailValid(fail_valid), .FailA(fail_a), .FailB(fail_b), .FailCin(fail_cin),
    .FailSum(fail_sum), .FailCout(fail_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and retire scoreboard entries now due
  task automatic tick();
    @(negedge clk);
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      sb_t e;
      e = sb_q.pop_front();
      if (e.mis) exp_err++;
      check("err_count", 32'(err_count), 32'(exp_err));
    end
  endtask

  task automatic start_run(input int n);
    start   = 1'b1;
    num_vec = CNT_W'(n);
    tick();
    start   = 1'b0;
    exp_err = 0;
    exp_vec = 0;
  endtask

  // Drive one Valid vector; 'acc' says whether the checker should accept it
  task automatic send(input vec_rec_t v, input bit acc);
    sb_t e;
    valid = 1'b1;
    a = v.a; b = v.b; cin = v.cin; sum = v.sum; cout = v.cout;
    tick();
    valid = 1'b0;
    if (acc) begin
      e.due = cyc + 2;
      e.mis = ({v.cout, v.sum} != {v.gold_cout, v.gold_sum});
      sb_q.push_back(e);
      exp_vec++;
    end
    check("vec_count", 32'(vec_count), 32'(exp_vec));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_vec"}, 32'(vec_count), 0);
    check({tag, "_err"}, 32'(err_count), 0);
    check({tag, "_fvalid"}, 32'(fail_valid), 0);
    check({tag, "_ffields"}, 32'({fail_a, fail_b, fail_cin, fail_sum, fail_cout}), 0);
  endtask

  initial begin
    // a, b, cin, sum, cout, gold_sum, gold_cout
    tbl[0]  = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0};
    tbl[1]  = '{4'h2, 4'hF, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1};
    tbl[2]  = '{4'h4, 4'hE, 1'b1, 4'h3, 1'b1, 4'h3, 1'b1};
    tbl[3]  = '{4'h8, 4'hA, 1'b1, 4'h3, 1'b1, 4'h3, 1'b1};
    tbl[4]  = '{4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 4'h2, 1'b0};
    tbl[5]  = '{4'h2, 4'hF, 1'b0, 4'h0, 1'b1, 4'h1, 1'b1}; // faulty
    tbl[6]  = '{4'h3, 4'h3, 1'b0, 4'h0, 1'b0, 4'h6, 1'b0}; // faulty
    tbl[7]  = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 4'hF, 1'b1};
    tbl[8]  = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1};
    tbl[9]  = '{4'h5, 4'h6, 1'b1, 4'hC, 1'b0, 4'hC, 1'b0};
    tbl[10] = '{4'h7, 4'h7, 1'b0, 4'hF, 1'b0, 4'hE, 1'b0}; // faulty
    tbl[11] = '{4'h9, 4'h9, 1'b0, 4'h2, 1'b1, 4'h2, 1'b1};

    rst_n = 1'b0; start = 1'b0; num_vec = '0; valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; sum = '0; cout = 1'b0;
    #12;
    check_idle_zero("reset");
    rst_n = 1'b1;
    tick();

    // Clean run of 4, with a Start pulse mid-run that must be ignored
    start_run(4);
    check("clean_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      send(tbl[i], 1'b1);
      if (i == 1) begin
        start = 1'b1; num_vec = CNT_W'(1);
        tick();
        start = 1'b0;
        check("start_in_run_busy", 32'(busy), 1);
      end
    end
    check("clean_drain1_done", 32'(done), 0);
    check("clean_drain1_busy", 32'(busy), 1);
    tick();
    check("clean_drain2_done", 32'(done), 0);
    tick();
    check("clean_done", 32'(done), 1);
    check("clean_busy_off", 32'(busy), 0);
    check("clean_pass", 32'(pass), 1);
    check("clean_vec", 32'(vec_count), 4);
    check("clean_fvalid", 32'(fail_valid), 0);

    // Injected faults: first failing vector must be kept
    start_run(3);
    for (int i = 4; i < 7; i++) send(tbl[i], 1'b1);
    tick(); tick();
    check("fault_done", 32'(done), 1);
    check("fault_err", 32'(err_count), 2);
    check("fault_pass", 32'(pass), 0);
    check("fault_fvalid", 32'(fail_valid), 1);
    check("fault_fail_a", 32'(fail_a), 32'h2);
    check("fault_fail_b", 32'(fail_b), 32'hF);
    check("fault_fail_cin", 32'(fail_cin), 0);
    check("fault_fail_sum", 32'(fail_sum), 0);
    check("fault_fail_cout", 32'(fail_cout), 1);

    // Back-to-back Start from DONE clears the failing result; bubbles 1,0,0,1
    start_run(2);
    check("b2b_err_clear", 32'(err_count), 0);
    check("b2b_fvalid_clear", 32'(fail_valid), 0);
    check("b2b_busy", 32'(busy), 1);
    send(tbl[7], 1'b1);
    tick();
    check("bubble1_vec", 32'(vec_count), 1);
    tick();
    check("bubble2_vec", 32'(vec_count), 1);
    check("bubble_busy", 32'(busy), 1);
    send(tbl[8], 1'b1);
    tick();
    check("bubble_drain_done", 32'(done), 0);
    tick();
    check("bubble_done", 32'(done), 1);
    check("bubble_pass", 32'(pass), 1);

    // NumVec = 0 finishes immediately; Valid in DONE is ignored
    start_run(0);
    check("zero_done", 32'(done), 1);
    check("zero_pass", 32'(pass), 1);
    check("zero_err", 32'(err_count), 0);
    send(tbl[9], 1'b0);
    tick();
    check("zero_done_vec", 32'(vec_count), 0);
    check("zero_done_err", 32'(err_count), 0);

    // Valid in IDLE is ignored
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    send(tbl[10], 1'b0);
    tick(); tick();
    check_idle_zero("idle_valid");

    // Reset mid-run after 2 of 5 vectors, one faulty
    start_run(5);
    send(tbl[9], 1'b1);
    send(tbl[10], 1'b1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    sb_q.delete();
    exp_err = 0; exp_vec = 0;
    check_idle_zero("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    start_run(1);
    send(tbl[11], 1'b1);
    tick(); tick();
    check("post_rst_done", 32'(done), 1);
    check("post_rst_pass", 32'(pass), 1);
    check("post_rst_err", 32'(err_count), 0);

    check("sb_drained", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_response_checker.md
Name: adder_response_checker

Overview:
- Self-checking monitor on the output side of FourBitFullAdder: takes each applied operand set plus the DUT's Sum/Cout and compares them against a golden A+B+Cin.
- Counts vectors and mismatches, captures the first failing vector, and reports pass/fail once a programmed number of vectors has been checked.
- Sits beside the adder in bench and board-level self-test wrappers; it replaces eyeballed waveforms for adder regressions.

Parameters:
- WIDTH, 4, operand width of A, B and Sum.
- CNT_W, 16, width of the vector-count and error-count counters.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Start  input  1  single-cycle pulse that arms a run; honoured only in IDLE or DONE.
- NumVec  input  CNT_W  number of vectors to check; sampled on Start.
- Valid  input  1  A/B/Cin/Sum/Cout are a valid vector this cycle.
- A  input  WIDTH  operand A as applied to the adder.
- B  input  WIDTH  operand B as applied to the adder.
- Cin  input  1  carry-in as applied to the adder.
- Sum  input  WIDTH  DUT sum.
- Cout  input  1  DUT carry-out.
- Busy  output  1  high in RUN and DRAIN.
- Done  output  1  high in DONE.
- Pass  output  1  valid while Done: 1 when ErrCount==0.
- VecCount  output  CNT_W  vectors accepted this run.
- ErrCount  output  CNT_W  mismatching vectors this run.
- FailValid  output  1  sticky; the first mismatch has been captured.
- FailA, FailB  output  WIDTH  operands of the first mismatch.
- FailCin  output  1  carry-in of the first mismatch.
- FailSum  output  WIDTH  DUT Sum of the first mismatch.
- FailCout  output  1  DUT Cout of the first mismatch.

Behaviour:
- Reset (async, Rst_n=0):
  - state=IDLE.
  - All outputs 0, including Pass, all Fail* fields and both counters.
  - Pipeline valid bits cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + Start: latch NumVec, clear counters, FailValid and the Fail* fields.
    - If NumVec==0, go to DONE with Pass=1.
    - Otherwise go to RUN.
  - RUN: each cycle with Valid=1 accepts one vector into stage 1 and increments VecCount. When the accepted vector is the NumVec-th, go to DRAIN on the next edge. Valid=0 cycles are bubbles and are not counted.
  - DRAIN: waits until stage 2 is empty, so the last compare has committed, then goes to DONE. DRAIN lasts exactly 2 cycles after the final accept.
  - DONE: Done=1 and Pass=(ErrCount==0). Held until Start or reset.
- Valid outside RUN: ignored, with no count and no compare. Valid in the same cycle as Start is also ignored.
- Start while in RUN or DRAIN: ignored.
- Pipeline (2 stages, fixed latency):
  - Stage 1 registers A, B, Cin, Sum and Cout.
  - Stage 2 computes exp = A + B + Cin at WIDTH+1 bits, zero-extended. It flags a mismatch when {Cout,Sum} != exp.
  - ErrCount updates 2 cycles after the vector is accepted.
- First-fail capture: on the first mismatch of a run, FailValid=1 and the Fail* fields take the stage-2 contents. Later mismatches do not overwrite them.
- Counters saturate at 2^CNT_W-1 and do not wrap. VecCount can reach NumVec at most, so saturation in practice affects ErrCount only.
- Reset mid-run: abandons the run immediately and returns to reset values. No partial result is retained.

Test Plan:
- Clean run: NumVec=4; vectors (0,0,0)->0/0, (2,F,0)->1/1, (4,E,1)->3/1, (8,A,1)->3/1 as Sum/Cout.
  - Done 2 cycles after the 4th accept.
  - Pass=1, VecCount=4, ErrCount=0, FailValid=0.
- Injected fault: NumVec=3; second vector A=2, B=F, Cin=0 with DUT Sum=0, Cout=1 (expected 1/1); third vector also wrong.
  - ErrCount=2, Pass=0, FailValid=1.
  - FailA=2, FailB=F, FailCin=0, FailSum=0, FailCout=1 (first fail kept).
- Bubbles and edge values: NumVec=2, with Valid toggled 1,0,0,1; vectors (F,F,1)->F/1 and (F,0,1)->0/1.
  - Gaps are not counted and Done still arrives 2 cycles after the 2nd accept.
  - Pass=1.
- NumVec=0 with Start: next cycle Done=1, Pass=1, counters 0. Valid pulses in IDLE and DONE leave VecCount=0.
- Reset mid-run: assert Rst_n=0 after 2 of 5 vectors, one of which mismatched.
  - All outputs 0 immediately, state IDLE.
  - A new Start with NumVec=1 and a good vector gives Pass=1 and ErrCount=0.
- Start during RUN is ignored and the run completes with the original NumVec. Back-to-back Start from DONE clears ErrCount and FailValid from the previous failing run.
